// File: rtl/cbus_rr_arbiter_if.sv
// cbus_rr_arbiter_if: cbus request/response types and the arbiter's bus bundle.
//   ireqs[NUM_PORTS]  : upstream master requests (into arbiter)
//   iresps[NUM_PORTS] : upstream responses (out of arbiter)
//   oreq              : request towards the memory/AXI bridge
//   oresp             : response from the memory/AXI bridge
//   modport slave     : arbiter view; modport master : environment view
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        okay;
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

interface cbus_rr_arbiter_if
    import cbus_pkg::*;
#(
    parameter int NUM_PORTS = 2
) ();
    cbus_req_t  ireqs  [NUM_PORTS];
    cbus_resp_t iresps [NUM_PORTS];
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    modport slave  (input ireqs, oresp, output iresps, oreq);
    modport master (output ireqs, oresp, input iresps, oreq);
endinterface

// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: round-robin arbiter granting whole cbus transactions (single or burst) to one master.
//   clk         : system clock
//   resetn      : asynchronous active-low reset
//   bus         : cbus_rr_arbiter_if.slave (ireqs/iresps upstream, oreq/oresp to memory side)
//   busy        : a transaction is granted
//   grant_idx   : index of current/last granted port
//   err_timeout : sticky watchdog flag
// Optional watchdog enabled by defining CBUS_ARB_TIMEOUT_EN.
module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         resetn,
    cbus_rr_arbiter_if.slave             bus,
    output logic                         busy,
    output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
    output logic                         err_timeout
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("cbus_rr_arbiter: illegal parameters");
    end

    logic [0:0]    state;
    logic [PW-1:0] rr;
    logic [PW-1:0] pick;
    logic [PW-1:0] nxt;
    logic          any;
    logic          done;
    logic          tmo;

    assign busy = state == BUSY;
    assign done = busy && bus.oresp.ready && bus.oresp.last;
    assign nxt  = grant_idx == PW'(NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;

    // Scan downwards so the lowest offset from rr is the last (winning) assignment.
    always_comb begin
        logic [PW:0] s;
        s    = '0;
        pick = rr;
        any  = 1'b0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            s = {1'b0, rr} + (PW+1)'(k);
            s = s >= (PW+1)'(NUM_PORTS) ? s - (PW+1)'(NUM_PORTS) : s;
            if (bus.ireqs[s[PW-1:0]].valid) begin
                pick = s[PW-1:0];
                any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr        <= '0;
        end else if (state == IDLE) begin
            if (any) begin
                state     <= BUSY;
                grant_idx <= pick;
            end
        end else if (done || tmo) begin
            state <= IDLE;
            rr    <= nxt;
        end
    end

`ifdef CBUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          err_q;

    // cnt holds (BUSY cycle number - 1), so the watchdog fires on BUSY cycle TIMEOUT_CYCLES.
    assign tmo         = busy && !done && cnt == CW'(TIMEOUT_CYCLES - 1);
    assign err_timeout = err_q | tmo;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt   <= busy ? cnt + 1'b1 : '0;
            err_q <= err_q | tmo;
        end
    end
`else
    assign tmo         = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Only the granted master sees the memory response; a watchdog abort fakes an error last beat.
    always_comb begin
        bus.oreq = '0;
        for (int i = 0; i < NUM_PORTS; i++) bus.iresps[i] = '0;
        if (busy) begin
            bus.oreq = bus.ireqs[grant_idx];
            bus.iresps[grant_idx] = tmo ? cbus_resp_t'{okay: 1'b0, ready: 1'b1, last: 1'b1, data: '0}
                                        : bus.oresp;
        end
    end
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: directed self-checking bench for cbus_rr_arbiter.
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

`ifdef CBUS_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       busy;
    logic [0:0] grant_idx;
    logic       err_timeout;
    int         errs = 0;
    int         checks = 0;

    cbus_rr_arbiter_if #(.NUM_PORTS(2)) bus ();

    cbus_rr_arbiter #(.NUM_PORTS(2), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus),
        .busy        (busy),
        .grant_idx   (grant_idx),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    function automatic cbus_req_t mk(input logic [31:0] a, input logic [7:0] l, input logic w);
        return '{valid: 1'b1, is_write: w, size: 3'd2, addr: a, strobe: 4'hf, data: ~a, len: l, burst: 2'b01};
    endfunction

    function automatic cbus_resp_t rsp(input logic r, input logic l, input logic [31:0] d);
        return '{okay: 1'b1, ready: r, last: l, data: d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ireqs[0] = '0;
        bus.ireqs[1] = '0;
        bus.oresp    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            checks++; if (bus.oreq !== '0) begin errs++; $display("FAIL reset_oreq: got %h want 0", bus.oreq); end
            checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
            checks++; if (bus.iresps[0] !== '0 || bus.iresps[1] !== '0) begin errs++; $display("FAIL reset_iresps: got %h %h want 0", bus.iresps[0], bus.iresps[1]); end
            checks++; if (grant_idx !== 1'b0) begin errs++; $display("FAIL reset_grant: got %b want 0", grant_idx); end
            checks++; if (err_timeout !== 1'b0) begin errs++; $display("FAIL reset_err: got %b want 0", err_timeout); end
            tick();
        end
    endtask

    task automatic test_single();
        bus.ireqs[0] = mk(32'h8000_0010, 8'd0, 1'b0);
        #1;
        checks++; if (busy !== 1'b0 || bus.oreq.valid !== 1'b0) begin errs++; $display("FAIL single_same_cycle: got busy=%b valid=%b want 0 0", busy, bus.oreq.valid); end
        tick();
        checks++; if (busy !== 1'b1 || grant_idx !== 1'b0) begin errs++; $display("FAIL single_grant: got busy=%b idx=%b want 1 0", busy, grant_idx); end
        checks++; if (bus.oreq.addr !== 32'h8000_0010 || bus.oreq.valid !== 1'b1) begin errs++; $display("FAIL single_oreq: got %h/%b want 80000010/1", bus.oreq.addr, bus.oreq.valid); end
        tick();
        tick();
        bus.oresp = rsp(1'b1, 1'b1, 32'hDEAD_BEEF);
        #1;
        checks++; if (bus.iresps[0].data !== 32'hDEAD_BEEF || bus.iresps[0].last !== 1'b1 || bus.iresps[0].ready !== 1'b1) begin errs++; $display("FAIL single_resp: got %h want DEADBEEF with ready/last", bus.iresps[0]); end
        checks++; if (bus.iresps[1] !== '0) begin errs++; $display("FAIL single_other: got %h want 0", bus.iresps[1]); end
        tick();
        clear_inputs();
        #1;
        checks++; if (busy !== 1'b0 || bus.oreq !== '0) begin errs++; $display("FAIL single_release: got busy=%b oreq=%h want 0", busy, bus.oreq); end
        tick();
        checks++; if (busy !== 1'b0 || bus.iresps[0] !== '0) begin errs++; $display("FAIL single_idle: got busy=%b resp=%h want 0", busy, bus.iresps[0]); end
    endtask

    task automatic test_burst();
        int n0 = 0;
        int n1 = 0;
        do_reset();
        bus.ireqs[0] = mk(32'h1000_0000, 8'd3, 1'b0);
        bus.ireqs[1] = mk(32'h2000_0000, 8'd3, 1'b0);
        tick();
        checks++; if (grant_idx !== 1'b0 || bus.oreq.addr !== 32'h1000_0000) begin errs++; $display("FAIL burst_first: got idx=%b addr=%h want 0 10000000", grant_idx, bus.oreq.addr); end
        for (int b = 0; b < 4; b++) begin
            bus.oresp = rsp(1'b1, b == 3, 32'(b));
            #1;
            n0 += int'(bus.iresps[0].ready);
            checks++; if (bus.iresps[1] !== '0 || busy !== 1'b1) begin errs++; $display("FAIL burst_p0_beat%0d: got resp1=%h busy=%b want 0 1", b, bus.iresps[1], busy); end
            tick();
        end
        bus.ireqs[0] = '0;
        bus.oresp    = '0;
        #1;
        checks++; if (busy !== 1'b0 || bus.oreq !== '0) begin errs++; $display("FAIL burst_bubble: got busy=%b oreq=%h want 0", busy, bus.oreq); end
        checks++; if (n0 !== 4) begin errs++; $display("FAIL burst_p0_beats: got %0d want 4", n0); end
        tick();
        checks++; if (busy !== 1'b1 || grant_idx !== 1'b1 || bus.oreq.addr !== 32'h2000_0000) begin errs++; $display("FAIL burst_second: got busy=%b idx=%b addr=%h want 1 1 20000000", busy, grant_idx, bus.oreq.addr); end
        for (int b = 0; b < 4; b++) begin
            bus.oresp = rsp(1'b1, b == 3, 32'(b + 16));
            #1;
            n1 += int'(bus.iresps[1].ready);
            checks++; if (bus.iresps[0] !== '0) begin errs++; $display("FAIL burst_p1_beat%0d: got resp0=%h want 0", b, bus.iresps[0]); end
            tick();
        end
        bus.ireqs[1] = '0;
        bus.oresp    = rsp(1'b1, 1'b1, 32'h5555_5555);
        #1;
        checks++; if (bus.iresps[0] !== '0 || bus.iresps[1] !== '0) begin errs++; $display("FAIL idle_ready_ignored: got %h %h want 0", bus.iresps[0], bus.iresps[1]); end
        checks++; if (n1 !== 4) begin errs++; $display("FAIL burst_p1_beats: got %0d want 4", n1); end
        tick();
        bus.oresp = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.ireqs[0] = mk(32'h3000_0000, 8'd0, 1'b0);
        bus.ireqs[1] = mk(32'h4000_0000, 8'd0, 1'b1);
        tick();
        checks++; if (grant_idx !== 1'b0) begin errs++; $display("FAIL rr_first: got %b want 0", grant_idx); end
        bus.oresp = rsp(1'b1, 1'b1, 32'h0);
        tick();
        bus.ireqs[0] = mk(32'h3000_0040, 8'd0, 1'b0);
        bus.oresp    = '0;
        tick();
        checks++; if (grant_idx !== 1'b1 || bus.oreq.addr !== 32'h4000_0000) begin errs++; $display("FAIL rr_no_starve: got idx=%b addr=%h want 1 40000000", grant_idx, bus.oreq.addr); end
        bus.oresp = rsp(1'b1, 1'b1, 32'h0);
        tick();
        bus.ireqs[1] = '0;
        bus.oresp    = '0;
        tick();
        checks++; if (grant_idx !== 1'b0 || bus.oreq.addr !== 32'h3000_0040) begin errs++; $display("FAIL rr_return: got idx=%b addr=%h want 0 30000040", grant_idx, bus.oreq.addr); end
        bus.oresp = rsp(1'b1, 1'b1, 32'h0);
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_valid_drop();
        do_reset();
        bus.ireqs[0] = mk(32'h5000_0000, 8'd1, 1'b0);
        tick();
        bus.ireqs[0].valid = 1'b0;
        bus.ireqs[1] = mk(32'h6000_0000, 8'd0, 1'b0);
        tick();
        checks++; if (busy !== 1'b1 || grant_idx !== 1'b0 || bus.oreq.valid !== 1'b0) begin errs++; $display("FAIL drop_hold: got busy=%b idx=%b valid=%b want 1 0 0", busy, grant_idx, bus.oreq.valid); end
        bus.oresp = rsp(1'b1, 1'b1, 32'h0);
        tick();
        bus.oresp = '0;
        tick();
        checks++; if (grant_idx !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL drop_release: got idx=%b busy=%b want 1 1", grant_idx, busy); end
        bus.oresp = rsp(1'b1, 1'b1, 32'h0);
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.ireqs[0] = mk(32'h7000_0000, 8'd0, 1'b0);
        tick();
        bus.oresp = rsp(1'b1, 1'b1, 32'h0);
        tick();
        bus.ireqs[0] = '0;
        bus.ireqs[1] = mk(32'h7100_0000, 8'd3, 1'b1);
        bus.oresp    = '0;
        tick();
        checks++; if (grant_idx !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL rmid_grant: got idx=%b busy=%b want 1 1", grant_idx, busy); end
        bus.oresp = rsp(1'b1, 1'b0, 32'h0);
        tick();
        #1;
        resetn = 1'b0;
        #1;
        checks++; if (bus.oreq.valid !== 1'b0 || busy !== 1'b0 || bus.iresps[1] !== '0) begin errs++; $display("FAIL rmid_async: got valid=%b busy=%b resp=%h want 0 0 0", bus.oreq.valid, busy, bus.iresps[1]); end
        clear_inputs();
        tick();
        resetn = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || grant_idx !== 1'b0) begin errs++; $display("FAIL rmid_after: got busy=%b idx=%b want 0 0", busy, grant_idx); end
        bus.ireqs[0] = mk(32'h7200_0000, 8'd0, 1'b0);
        bus.ireqs[1] = mk(32'h7300_0000, 8'd0, 1'b0);
        tick();
        checks++; if (grant_idx !== 1'b0) begin errs++; $display("FAIL rmid_rr_reset: got %b want 0", grant_idx); end
        bus.oresp = rsp(1'b1, 1'b1, 32'h0);
        tick();
        clear_inputs();
        tick();
    endtask

`ifdef CBUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        bus.ireqs[0] = mk(32'h9000_0000, 8'd0, 1'b0);
        bus.ireqs[1] = mk(32'h9100_0000, 8'd0, 1'b0);
        tick();
        for (int c = 1; c < 15; c++) tick();
        checks++; if (err_timeout !== 1'b0 || bus.iresps[0].ready !== 1'b0) begin errs++; $display("FAIL tmo_early: got err=%b ready=%b want 0 0", err_timeout, bus.iresps[0].ready); end
        tick();
        checks++; if (err_timeout !== 1'b1) begin errs++; $display("FAIL tmo_flag: got %b want 1", err_timeout); end
        checks++; if (bus.iresps[0].ready !== 1'b1 || bus.iresps[0].last !== 1'b1 || bus.iresps[0].okay !== 1'b0) begin errs++; $display("FAIL tmo_resp: got %h want ready=1 last=1 okay=0", bus.iresps[0]); end
        tick();
        bus.ireqs[0] = '0;
        checks++; if (busy !== 1'b0 || err_timeout !== 1'b1 || bus.iresps[0] !== '0) begin errs++; $display("FAIL tmo_after: got busy=%b err=%b resp=%h want 0 1 0", busy, err_timeout, bus.iresps[0]); end
        tick();
        checks++; if (grant_idx !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL tmo_next: got idx=%b busy=%b want 1 1", grant_idx, busy); end
        clear_inputs();
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_burst();
        test_back_to_back();
        test_valid_drop();
        test_reset_mid();
`ifdef CBUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/cbus_rr_arbiter.md
Name: cbus_rr_arbiter

Overview:
- Sits directly downstream of the data cache and instruction cache cbus master ports; owns the single cbus path to the memory/AXI bridge.
- Accepts NUM_PORTS cbus_req_t streams and grants one complete transaction (single or burst) at a time, round-robin.
- Forwards responses only to the granted master.
- Holds the grant until the final beat, so a cache line refill/writeback burst is never interleaved.

Parameters:
- NUM_PORTS, 2, number of upstream cbus masters; index 0 = DCache, 1 = ICache; legal range 2..8.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- ireqs  in  cbus_req_t[NUM_PORTS]  upstream requests (valid, is_write, size, addr, strobe, data, len, burst)
- iresps  out  cbus_resp_t[NUM_PORTS]  upstream responses (okay, ready, last, data)
- oreq  out  cbus_req_t  request to memory side
- oresp  in  cbus_resp_t  response from memory side
- busy  out  1  a transaction is granted
- grant_idx  out  $clog2(NUM_PORTS)  index of current/last granted port
- err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (resetn low, asynchronous): state IDLE, busy=0, grant_idx=0, rr pointer=0, err_timeout=0. oreq is all-zero and every iresps[i] is all-zero, as soon as reset asserts.
- States:
  - IDLE: scan ports starting at rr pointer, wrapping modulo NUM_PORTS. First port with ireqs[i].valid=1 is latched into grant_idx. Go to BUSY at the next edge. With no valid port, stay IDLE.
  - BUSY:
    - oreq = ireqs[grant_idx] (combinational pass-through).
    - iresps[grant_idx] = oresp; every other iresps[j] = 0.
    - When oresp.ready && oresp.last in a cycle: return to IDLE next edge, and set rr pointer = (grant_idx+1) mod NUM_PORTS.
- In IDLE: oreq = 0, all iresps = 0.
- Latency: request first visible at cycle t is presented on oreq at t+1. There is one mandatory IDLE cycle between back-to-back transactions (arbitration bubble).
- Single-beat transactions (len=0) complete on the first ready with last=1. A burst of len+1 beats completes only on last; ready without last keeps BUSY.
- Masters must hold valid and request fields stable until last. A valid drop while granted is a protocol violation: the arbiter keeps the grant (oreq.valid follows the master) and releases only on last.
- Simultaneous requests: rr pointer decides. A port granted at t cannot win again until each other continuously-valid port has been granted once (starvation-free).
- New request arriving in the same cycle as last: considered in the following IDLE cycle.
- oresp.ready asserted while IDLE: ignored, not routed.
- Reset asserted mid-burst: grant dropped immediately, oreq.valid=0. The memory side must also be reset.
- busy=1 exactly in BUSY.

Optional Feature:
- Macro: CBUS_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to BUSY and increments each BUSY cycle without ready&&last.
  - On reaching TIMEOUT_CYCLES, err_timeout sets and stays set until reset.
  - The arbiter forces IDLE, advances the rr pointer past the hung port, and drives iresps[grant_idx] with ready=1, last=1, okay=0 for that one cycle.
- Undefined: err_timeout tied 0, no counter; a hung slave holds the grant indefinitely.

Test Plan:
- Reset release with all valid=0 for 10 cycles -> oreq=0, busy=0, all iresps=0, grant_idx=0.
- Port0 single read addr 0x8000_0010, len=0; slave ready+last with data 0xDEADBEEF 3 cycles later -> oreq.addr=0x8000_0010 one cycle after request; iresps[0].data=0xDEADBEEF with last=1; iresps[1] stays 0; busy falls the next cycle.
- Port0 and port1 both issue 4-beat bursts (len=3) in the same cycle from reset -> port0 granted first; all 4 beats go to port0 only; one IDLE bubble; then port1 granted. Port1 receives exactly 4 ready beats.
- Port0 re-requests immediately after finishing while port1 is waiting -> port1 granted before port0's second transaction (round-robin, no starvation).
- Assert resetn=0 on beat 2 of a 4-beat write burst -> oreq.valid=0 in the same cycle without a clock edge; after release, state IDLE and rr pointer=0.
- With CBUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts ready -> at cycle 16 of BUSY, err_timeout=1 and iresps[0] shows ready=1, last=1, okay=0 for one cycle. A pending port1 request is then granted.
